// File: rtl/store_align_unit.sv
// Store alignment stage: rotates store data onto byte lanes, builds byte write
// enables and splits word-boundary-crossing stores into two RAM beats.
module store_align_unit #(
    parameter int ADDR_W         = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_mode,
    output logic              ram_en,
    input  logic              ram_ready,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    output logic              done,
    output logic              err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1. req_ready never depends on req_valid; ram_en is held, with all ram_*
    // stable, until ram_ready is seen high.

    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

    state_t            state, state_d;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       rot_q;
    logic [3:0]        m0_q, m1_q;
    logic              split_q;
    logic              done_q, err_q;

    logic [3:0]  base;
    logic [7:0]  lane_mask;
    logic [31:0] rot;
    logic        req_split, bad, accept, last_beat;

    // Request decode: size mask, shifted lane mask and lane rotation.
    always_comb begin
        base = 4'b0000;
        case (req_mode)
            3'b100:  base = 4'b1111;
            3'b010:  base = 4'b0011;
            3'b001:  base = 4'b0001;
            default: base = 4'b0000;
        endcase
        lane_mask = {4'b0000, base} << req_addr[1:0];
        req_split = |lane_mask[7:4];
        bad       = (base == 4'b0000) || (req_split && !ALLOW_MISALIGN);
        rot       = req_wdata;
        case (req_addr[1:0])
            2'd1:    rot = {req_wdata[23:0], req_wdata[31:24]};
            2'd2:    rot = {req_wdata[15:0], req_wdata[31:16]};
            2'd3:    rot = {req_wdata[7:0],  req_wdata[31:8]};
            default: rot = req_wdata;
        endcase
    end

    assign last_beat = (state == BEAT1) || ((state == BEAT0) && !split_q);
    assign req_ready = rst_n && ((state == IDLE) || (last_beat && ram_ready));
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            rot_q   <= '0;
            m0_q    <= '0;
            m1_q    <= '0;
            split_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= last_beat && ram_ready;
            err_q  <= accept && bad;
            if (accept && !bad) begin
                addr_q  <= req_addr[ADDR_W-1:2];
                rot_q   <= rot;
                m0_q    <= lane_mask[3:0];
                m1_q    <= lane_mask[7:4];
                split_q <= req_split;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept && !bad) state_d = BEAT0;
            BEAT0: begin
                if (ram_ready) begin
                    if (split_q)             state_d = BEAT1;
                    else if (accept && !bad) state_d = BEAT0;
                    else                     state_d = IDLE;
                end
            end
            BEAT1: begin
                if (ram_ready) state_d = (accept && !bad) ? BEAT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All ram_* outputs are forced to zero outside a beat.
    always_comb begin
        ram_en    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 4'b0000;
        case (state)
            BEAT0: begin
                ram_en    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = rot_q;
                ram_we    = m0_q;
            end
            BEAT1: begin
                ram_en    = 1'b1;
                ram_addr  = addr_q + {{(ADDR_W-3){1'b0}}, 1'b1};
                ram_wdata = rot_q;
                ram_we    = m1_q;
            end
            default: ;
        endcase
        done = done_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: one instance splits misaligned stores,
// a second instance sharing the same inputs rejects them.
module tb_store_align_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mode;
    logic        ram_ready;

    logic        req_ready, ram_en, done, err;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_we;

    logic        req_ready_b, ram_en_b, done_b, err_b;
    logic [29:0] ram_addr_b;
    logic [31:0] ram_wdata_b;
    logic [3:0]  ram_we_b;

    int tests = 0;
    int fails = 0;

    store_align_unit #(.ADDR_W(32), .ALLOW_MISALIGN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
        .ram_en(ram_en), .ram_ready(ram_ready), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .done(done), .err(err)
    );

    store_align_unit #(.ADDR_W(32), .ALLOW_MISALIGN(1'b0)) u_strict (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
        .ram_en(ram_en_b), .ram_ready(ram_ready), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns just after that edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_mode  = m;
        step();
        req_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [29:0] a, input logic [3:0] we,
                            input logic [31:0] d);
        chk({tag, "_en"},    64'(ram_en),    64'd1);
        chk({tag, "_addr"},  64'(ram_addr),  64'(a));
        chk({tag, "_we"},    64'(ram_we),    64'(we));
        chk({tag, "_wdata"}, 64'(ram_wdata), 64'(d));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mode  = 3'b000;
        ram_ready = 1'b1;
        step();
        step();
        chk("rst_en",    64'(ram_en),    64'd0);
        chk("rst_we",    64'(ram_we),    64'd0);
        chk("rst_addr",  64'(ram_addr),  64'd0);
        chk("rst_wdata", 64'(ram_wdata), 64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_err",   64'(err),       64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd1);

        // Aligned word
        send(32'h0000_0100, 32'hAABB_CCDD, 3'b100);
        chk_beat("word", 30'h40, 4'b1111, 32'hAABB_CCDD);
        chk("word_done0", 64'(done), 64'd0);
        step();
        chk("word_done1", 64'(done),   64'd1);
        chk("word_en0",   64'(ram_en), 64'd0);
        chk("word_we0",   64'(ram_we), 64'd0);
        step();
        chk("word_done2", 64'(done), 64'd0);

        // Byte and half lanes
        send(32'h0000_0103, 32'h0000_005A, 3'b001);
        chk_beat("byte", 30'h40, 4'b1000, 32'h5A00_0000);
        step();
        chk("byte_done", 64'(done),   64'd1);
        chk("byte_en0",  64'(ram_en), 64'd0);
        send(32'h0000_0102, 32'h0000_1234, 3'b010);
        chk_beat("half", 30'h40, 4'b1100, 32'h1234_0000);
        step();
        chk("half_done", 64'(done),   64'd1);
        chk("half_en0",  64'(ram_en), 64'd0);

        // Split word
        send(32'h0000_0101, 32'h1122_3344, 3'b100);
        chk_beat("split_b0", 30'h40, 4'b1110, 32'h2233_4411);
        chk("split_b0_done", 64'(done), 64'd0);
        step();
        chk_beat("split_b1", 30'h41, 4'b0001, 32'h2233_4411);
        chk("split_b1_done", 64'(done), 64'd0);
        step();
        chk("split_done", 64'(done),   64'd1);
        chk("split_en0",  64'(ram_en), 64'd0);
        step();
        chk("split_done_pulse", 64'(done), 64'd0);

        // Backpressure and address wrap
        ram_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b010);
        chk_beat("wrap_b0", 30'h3FFF_FFFF, 4'b1000, 32'hEF00_00BE);
        chk("wrap_b0_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_beat("wrap_hold", 30'h3FFF_FFFF, 4'b1000, 32'hEF00_00BE);
            chk("wrap_hold_done", 64'(done), 64'd0);
        end
        ram_ready = 1'b1;
        step();
        chk_beat("wrap_b1", 30'h0, 4'b0001, 32'hEF00_00BE);
        step();
        chk("wrap_done", 64'(done),   64'd1);
        chk("wrap_en0",  64'(ram_en), 64'd0);

        // Invalid mode
        send(32'h0000_0100, 32'hDEAD_BEEF, 3'b011);
        chk("badmode_err",   64'(err),       64'd1);
        chk("badmode_en",    64'(ram_en),    64'd0);
        chk("badmode_ready", 64'(req_ready), 64'd1);
        step();
        chk("badmode_err0", 64'(err),    64'd0);
        chk("badmode_en1",  64'(ram_en), 64'd0);
        chk("badmode_done", 64'(done),   64'd0);

        // Misaligned word: rejected by the strict instance, split by the other
        send(32'h0000_0102, 32'hCAFE_F00D, 3'b100);
        chk("strict_err",  64'(err_b),    64'd1);
        chk("strict_en",   64'(ram_en_b), 64'd0);
        chk("strict_we",   64'(ram_we_b), 64'd0);
        chk("relaxed_err", 64'(err),      64'd0);
        chk_beat("relaxed_b0", 30'h40, 4'b1100, 32'hF00D_CAFE);
        step();
        chk("strict_err0", 64'(err_b),    64'd0);
        chk("strict_en1",  64'(ram_en_b), 64'd0);
        chk_beat("relaxed_b1", 30'h41, 4'b0011, 32'hF00D_CAFE);
        step();
        chk("relaxed_done", 64'(done),   64'd1);
        chk("strict_done",  64'(done_b), 64'd0);

        // Back-to-back aligned words
        req_valid = 1'b1;
        req_addr  = 32'h0000_0200;
        req_wdata = 32'h0000_0001;
        req_mode  = 3'b100;
        step();
        req_addr  = 32'h0000_0204;
        req_wdata = 32'h0000_0002;
        chk_beat("b2b_1", 30'h80, 4'b1111, 32'h0000_0001);
        chk("b2b_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk_beat("b2b_2", 30'h81, 4'b1111, 32'h0000_0002);
        chk("b2b_done1", 64'(done), 64'd1);
        step();
        chk("b2b_done2", 64'(done),   64'd1);
        chk("b2b_en0",   64'(ram_en), 64'd0);

        // Reset during the second beat of a split store
        send(32'h0000_0101, 32'h1122_3344, 3'b100);
        step();
        chk_beat("rstmid_b1", 30'h41, 4'b0001, 32'h2233_4411);
        rst_n = 1'b0;
        step();
        chk("rstmid_en",    64'(ram_en),    64'd0);
        chk("rstmid_we",    64'(ram_we),    64'd0);
        chk("rstmid_done",  64'(done),      64'd0);
        chk("rstmid_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rstmid_ready1", 64'(req_ready), 64'd1);
        step();
        chk("rstmid_done1", 64'(done),   64'd0);
        chk("rstmid_en1",   64'(ram_en), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
